// File: rtl/poly_sweep_ctrl_if.sv
// Evaluator job port and result stream for poly_sweep_ctrl, bundled as one interface.
// master = sweep controller side, slave = evaluator plus downstream consumer side.
interface poly_sweep_ctrl_if #(
  parameter int W  = 16,
  parameter int CW = 8
) ();
  logic          eval_start;
  logic [W-1:0]  eval_x;
  logic          eval_done;
  logic [W-1:0]  eval_result;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_idx;
  logic [W-1:0]  out_x;
  logic [W-1:0]  out_y;

  modport master (
    output eval_start, eval_x, out_valid, out_idx, out_x, out_y,
    input  eval_done, eval_result, out_ready
  );

  modport slave (
    input  eval_start, eval_x, out_valid, out_idx, out_x, out_y,
    output eval_done, eval_result, out_ready
  );
endinterface

// File: rtl/poly_sweep_ctrl.sv
// Sweep sequencer: issues one evaluator job per X = first + i*step and streams (idx, x, y).
// Optional macro SWEEP_TIMEOUT_EN adds a WAIT watchdog that aborts to IDLE with a sticky err.
module poly_sweep_ctrl #(
  parameter int W              = 16,
  parameter int CW             = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  go,
  input  logic                  abort,
  input  logic [W-1:0]          x_first,
  input  logic [W-1:0]          x_step,
  input  logic [CW-1:0]         count,
  poly_sweep_ctrl_if.master     bus,
  output logic                  busy,
  output logic                  finished,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  x_cur, step_q;
  logic [CW-1:0] remaining, idx;
  logic [CW-1:0] out_idx_q;
  logic [W-1:0]  out_x_q, out_y_q;
  logic          fin_q;
  logic          go_ok, start_sweep, handshake, last_beat, capture, timeout;

  assign go_ok       = (state == IDLE) && go && !abort;
  assign start_sweep = go_ok && (count != '0);
  assign handshake   = (state == PUSH) && bus.out_ready && !abort;
  assign last_beat   = handshake && (remaining == CW'(1));
  assign capture     = (state == WAIT) && bus.eval_done && !abort;

`ifdef SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  // Counter is held at zero outside WAIT, so it is always fresh on WAIT entry.
  assign timeout = (state == WAIT) && !bus.eval_done && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + TW'(1) : '0;
      if (go_ok)                  err <= 1'b0;
      else if (timeout && !abort) err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_sweep) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.eval_done) state_nxt = PUSH;
        else if (timeout)  state_nxt = IDLE;
      end
      PUSH:  if (bus.out_ready) state_nxt = (remaining == CW'(1)) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      x_cur     <= '0;
      step_q    <= '0;
      remaining <= '0;
      idx       <= '0;
      out_idx_q <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      fin_q     <= 1'b0;
    end else begin
      fin_q <= go_ok && (count == '0);
      if (start_sweep) begin
        x_cur     <= x_first;
        step_q    <= x_step;
        remaining <= count;
        idx       <= '0;
      end else if (handshake) begin
        remaining <= remaining - CW'(1);
        idx       <= idx + CW'(1);
        x_cur     <= x_cur + step_q;
      end
      if (capture) begin
        out_idx_q <= idx;
        out_x_q   <= x_cur;
        out_y_q   <= bus.eval_result;
      end
    end
  end

  assign bus.eval_start = (state == ISSUE);
  assign bus.eval_x     = x_cur;
  assign bus.out_valid  = (state == PUSH);
  assign bus.out_idx    = out_idx_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign busy           = (state != IDLE);
  // The last-beat term makes finished coincide with the final handshake.
  assign finished       = fin_q | last_beat;

endmodule

// File: tb/tb_poly_sweep_ctrl.sv
// Bench for poly_sweep_ctrl: evaluator model y=x*x+2x+3, transaction scoreboard, random sweeps.
// Define SWEEP_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_poly_sweep_ctrl;
  localparam int W  = 16;
  localparam int CW = 8;
  localparam int TO = 10;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b0;
  logic          go = 1'b0, abort = 1'b0;
  logic [W-1:0]  x_first = '0, x_step = '0;
  logic [CW-1:0] count = '0;
  logic          busy, finished, err;

  poly_sweep_ctrl_if #(.W(W), .CW(CW)) bus ();

  poly_sweep_ctrl #(.W(W), .CW(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk0(clk0), .rst0(rst0), .go(go), .abort(abort),
    .x_first(x_first), .x_step(x_step), .count(count),
    .bus(bus.master), .busy(busy), .finished(finished), .err(err)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic [CW-1:0] idx;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          last;
  } beat_t;

  int checks = 0, errors = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  logic [W-1:0] iss_q[$];
  int fin_exp = 0, fin_seen = 0, starts_seen = 0, valid_cycles = 0;
  int ready_mode = 0, ev_mode = 0, ev_lat = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] poly(input logic [W-1:0] x);
    int unsigned xi;
    xi = x;
    return W'(xi * xi + 2 * xi + 3);
  endfunction

  // Expected transactions of one sweep, straight from first/step/count.
  task automatic plan_sweep(input logic [W-1:0] first, input logic [W-1:0] step, input int n);
    logic [W-1:0] x;
    fin_exp++;
    for (int i = 0; i < n; i++) begin
      x = first + W'(i) * step;
      exp_q.push_back('{idx: CW'(i), x: x, y: poly(x), last: (i == n - 1)});
      iss_q.push_back(x);
    end
  endtask

  task automatic cycle();
    @(posedge clk0);
    #1;
  endtask

  // Evaluator: done pulses ev_lat cycles after the start cycle; result is junk otherwise.
  initial begin
    int timer;
    logic [W-1:0] ev_x;
    timer = 0;
    ev_x = '0;
    bus.eval_done = 1'b0;
    bus.eval_result = '0;
    forever begin
      @(negedge clk0);
      if (rst0 && bus.eval_start && ev_mode == 0) begin
        timer = ev_lat;
        ev_x = bus.eval_x;
      end
      @(posedge clk0);
      #1;
      bus.eval_done = 1'b0;
      bus.eval_result = W'($urandom);
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          bus.eval_done = 1'b1;
          bus.eval_result = poly(ev_x);
        end
      end
    end
  end

  // Downstream: always ready, random ready, or four stall cycles per beat.
  initial begin
    int stall;
    stall = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk0);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (stall >= 4);
      endcase
      @(negedge clk0);
      if (bus.out_valid && !bus.out_ready) stall++;
      else if (bus.out_valid)              stall = 0;
    end
  end

  // Compare process: every cycle against the scoreboard and the handshake timing rules.
  initial begin
    logic p_done, p_valid, p_ready, p_abort, p_busy, p_start, p_hs_more, hs;
    beat_t b;
    {p_done, p_valid, p_ready, p_abort, p_busy, p_start, p_hs_more} = '0;
    forever begin
      @(negedge clk0);
      if (rst0) begin
        hs = bus.out_valid && bus.out_ready && !abort;
        if (bus.out_valid) begin
          valid_cycles++;
          check("start_in_push", bus.eval_start, 1'b0);
          if (exp_q.size() == 0) begin
            check("spurious_valid", bus.out_valid, 1'b0);
          end else begin
            b = exp_q[0];
            check("out_idx", bus.out_idx, b.idx);
            check("out_x", bus.out_x, b.x);
            check("out_y", bus.out_y, b.y);
            if (hs) begin
              check("finished_on_hs", finished, b.last);
              log_q.push_back('{idx: bus.out_idx, x: bus.out_x, y: bus.out_y, last: finished});
              void'(exp_q.pop_front());
            end
          end
        end
        if (bus.eval_start) begin
          starts_seen++;
          if (iss_q.size() == 0) check("spurious_start", bus.eval_start, 1'b0);
          else                   check("eval_x", bus.eval_x, iss_q.pop_front());
        end
        if (finished) fin_seen++;
        if (bus.eval_start || bus.out_valid) check("busy_active", busy, 1'b1);
        if (p_done && p_busy && !p_valid && !p_start && !p_abort)
          check("valid_after_done", bus.out_valid, 1'b1);
        if (p_hs_more) check("start_after_hs", bus.eval_start, 1'b1);
        if (p_valid && !p_ready && !p_abort) check("valid_held", bus.out_valid, 1'b1);
`ifndef SWEEP_TIMEOUT_EN
        check("err_zero", err, 1'b0);
`endif
        p_hs_more = hs && (exp_q.size() != 0) && !finished;
        if (abort) begin
          if (exp_q.size() != 0) fin_exp--;
          exp_q.delete();
          iss_q.delete();
        end
        p_done  = bus.eval_done;
        p_valid = bus.out_valid;
        p_ready = bus.out_ready;
        p_abort = abort;
        p_busy  = busy;
        p_start = bus.eval_start;
      end
    end
  end

  task automatic issue_go(input logic [W-1:0] first, input logic [W-1:0] step, input int n);
    x_first = first;
    x_step  = step;
    count   = CW'(n);
    go      = 1'b1;
    plan_sweep(first, step, n);
    cycle();
    go = 1'b0;
    @(negedge clk0);
    check("go_start", bus.eval_start, (n != 0));
    check("go_busy", busy, (n != 0));
    check("go_finished", finished, (n == 0));
    cycle();
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) break;
      cycle();
    end
    check("sweep_in_budget", (i < budget), 1'b1);
  endtask

  task automatic check_sweep_2_3_3(input string tag);
    check({tag, "_beats"}, log_q.size(), 3);
    if (log_q.size() == 3) begin
      check({tag, "_b0"}, {log_q[0].idx, log_q[0].x, log_q[0].y}, {8'd0, 16'd2, 16'd11});
      check({tag, "_b1"}, {log_q[1].idx, log_q[1].x, log_q[1].y}, {8'd1, 16'd5, 16'd38});
      check({tag, "_b2"}, {log_q[2].idx, log_q[2].x, log_q[2].y}, {8'd2, 16'd8, 16'd83});
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int f0, s0, v0, n, k;
    repeat (3) cycle();
    @(negedge clk0);
    check("rst_busy", busy, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_start", bus.eval_start, 1'b0);
    check("rst_data", {bus.out_idx, bus.out_x, bus.out_y, bus.eval_x}, '0);
    cycle();
    rst0 = 1'b1;
    cycle();

    // Basic sweep, always ready.
    log_q.delete();
    f0 = fin_seen;
    issue_go(16'd2, 16'd3, 3);
    wait_done(200);
    check_sweep_2_3_3("t1");
    check("t1_fin_count", fin_seen - f0, 1);
    check("t1_busy_after", busy, 1'b0);

    // Same sweep with four stall cycles per beat.
    ready_mode = 2;
    log_q.delete();
    s0 = starts_seen;
    v0 = valid_cycles;
    issue_go(16'd2, 16'd3, 3);
    wait_done(300);
    check_sweep_2_3_3("t2");
    check("t2_starts", starts_seen - s0, 3);
    check("t2_valid_cycles", valid_cycles - v0, 15);
    ready_mode = 0;

    // Empty sweep.
    s0 = starts_seen;
    f0 = fin_seen;
    issue_go(16'd9, 16'd1, 0);
    @(negedge clk0);
    check("t3_fin_once", finished, 1'b0);
    check("t3_busy", busy, 1'b0);
    cycle();
    check("t3_starts", starts_seen - s0, 0);
    check("t3_fin_count", fin_seen - f0, 1);

    // X wraps modulo 2^W.
    log_q.delete();
    issue_go(16'hFFFE, 16'd2, 2);
    wait_done(200);
    check("t4_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_x0", log_q[0].x, 16'hFFFE);
      check("t4_x1", log_q[1].x, 16'h0000);
    end

    // Abort with go in the same cycle during WAIT of point 1.
    log_q.delete();
    f0 = fin_seen;
    s0 = starts_seen;
    issue_go(16'd2, 16'd3, 3);
    for (k = 0; k < 100 && starts_seen < s0 + 2; k++) cycle();
    check("t5_reach_point1", starts_seen, s0 + 2);
    cycle();
    abort = 1'b1;
    go = 1'b1;
    count = 8'd5;
    cycle();
    abort = 1'b0;
    go = 1'b0;
    @(negedge clk0);
    check("t5_idle", {busy, bus.out_valid, bus.eval_start}, 3'b000);
    repeat (12) cycle();
    check("t5_no_fin", fin_seen - f0, 0);
    check("t5_beats", log_q.size(), 1);
    issue_go(16'd7, 16'd1, 2);
    wait_done(200);
    check("t5_restart_beats", log_q.size(), 3);
    if (log_q.size() == 3) check("t5_restart_idx0", {log_q[1].idx, log_q[1].x}, {8'd0, 16'd7});

`ifdef SWEEP_TIMEOUT_EN
    // Evaluator never answers: watchdog returns to IDLE after TO cycles in WAIT.
    ev_mode = 1;
    issue_go(16'd5, 16'd1, 1);
    repeat (TO - 1) cycle();
    @(negedge clk0);
    check("t6_still_wait", {busy, err}, 2'b10);
    cycle();
    @(negedge clk0);
    check("t6_timed_out", {busy, err}, 2'b01);
    exp_q.delete();
    iss_q.delete();
    fin_exp--;
    ev_mode = 0;
    cycle();
    issue_go(16'd1, 16'd1, 1);
    check("t6_err_cleared", err, 1'b0);
    wait_done(200);
`endif

    // Random sweeps: random ready, latency, occasional abort and ignored go.
    ready_mode = 1;
    for (int s = 0; s < 24; s++) begin
      ev_lat = int'($urandom_range(1, 7));
      n = int'($urandom_range(1, 6));
      issue_go(W'($urandom), W'($urandom), n);
      for (k = 0; k < 300; k++) begin
        if (!busy && exp_q.size() == 0) break;
        if (busy && $urandom_range(0, 15) == 0) begin
          go = 1'b1;
          count = 8'd3;
        end
        if (busy && s % 4 == 3 && $urandom_range(0, 20) == 0) begin
          abort = 1'b1;
          cycle();
          abort = 1'b0;
          go = 1'b0;
          repeat (10) cycle();
        end else begin
          cycle();
          go = 1'b0;
        end
      end
      wait_done(300);
    end
    ready_mode = 0;
    repeat (10) cycle();

    check("fin_total", fin_seen, fin_exp);
    check("exp_drained", exp_q.size() + iss_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
